// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op codes, widths and FSM states.
package mdu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [OP_W-1:0] MDU_NONE  = 3'd0;
    localparam logic [OP_W-1:0] MDU_MULT  = 3'd1;
    localparam logic [OP_W-1:0] MDU_MULTU = 3'd2;
    localparam logic [OP_W-1:0] MDU_DIV   = 3'd3;
    localparam logic [OP_W-1:0] MDU_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] MDU_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] MDU_MTLO  = 3'd6;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/mdu.sv
// MIPS multiply/divide unit: HI/LO registers with a busy counter modelling latency.
// Define MDU_TRACE_EN to latch the issuing PC and print HI/LO commits.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [OP_W-1:0]   Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] PC,
    output logic              Busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              dz_q, dz_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] pend_lo_q, pend_lo_d;

    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic [DATA_W-1:0]   mag_a, mag_b, div_a, div_b, q_raw, r_raw, quot, rem;
    logic                is_sdiv;

    // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        prod_s  = {{DATA_W{A[DATA_W-1]}}, A} * {{DATA_W{B[DATA_W-1]}}, B};
        prod_u  = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
        mag_a   = A[DATA_W-1] ? (~A + 32'd1) : A;
        mag_b   = B[DATA_W-1] ? (~B + 32'd1) : B;
        is_sdiv = (Op == MDU_DIV);
        div_a   = is_sdiv ? mag_a : A;
        div_b   = is_sdiv ? mag_b : B;
        q_raw   = '0;
        r_raw   = '0;
        if (div_b != '0) begin
            q_raw = div_a / div_b;
            r_raw = div_a % div_b;
        end
        quot = (is_sdiv && (A[DATA_W-1] ^ B[DATA_W-1])) ? (~q_raw + 32'd1) : q_raw;
        rem  = (is_sdiv && A[DATA_W-1]) ? (~r_raw + 32'd1) : r_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (Start && !busy_q) begin
                    case (Op)
                        MDU_MULT, MDU_MULTU: begin
                            pend_hi_d = (Op == MDU_MULT) ? prod_s[2*DATA_W-1:DATA_W]
                                                         : prod_u[2*DATA_W-1:DATA_W];
                            pend_lo_d = (Op == MDU_MULT) ? prod_s[DATA_W-1:0]
                                                         : prod_u[DATA_W-1:0];
                            dz_d      = 1'b0;
                            cnt_d     = CNT_W'(MULT_CYCLES - 1);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            dz_d      = (B == '0);
                            cnt_d     = CNT_W'(DIV_CYCLES - 1);
                            busy_d    = 1'b1;
                            state_d   = RUN;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (!dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

`ifdef MDU_TRACE_EN
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              launch_c;

    always_comb begin
        launch_c = (state_q == IDLE) && Start && !busy_q &&
                   (Op == MDU_MULT || Op == MDU_MULTU || Op == MDU_DIV || Op == MDU_DIVU);
        pc_d     = launch_c ? PC : pc_q;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Same line format as the register-file trace.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            if (state_q == RUN && cnt_q == '0 && !dz_q) begin
                $display("%d@%h: $hi <= %h", $time, pc_q, pend_hi_q);
                $display("%d@%h: $lo <= %h", $time, pc_q, pend_lo_q);
            end else if (state_q == IDLE && Start && !busy_q && Op == MDU_MTHI) begin
                $display("%d@%h: $hi <= %h", $time, PC, A);
            end else if (state_q == IDLE && Start && !busy_q && Op == MDU_MTLO) begin
                $display("%d@%h: $lo <= %h", $time, PC, A);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC;
`endif

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, arithmetic corners, ignore-while-busy, reset.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A, B, PC;
    logic        Busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .PC    (PC),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        PC    = PC + 32'd4;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        Op    = MDU_NONE;
        A     = 32'hDEADBEEF;
        B     = 32'h0BADF00D;
    endtask

    task automatic busy_run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy_hi"}, {31'd0, Busy}, 32'd1);
            @(negedge clk);
        end
        chk({tag, "_busy_lo"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Op    = MDU_NONE;
        A     = '0;
        B     = '0;
        PC    = 32'h0040_0000;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);

        // MULT -2 * 3
        issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi_pre", HI, 32'h0);
        busy_run("mult", 5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);

        // MULTU 0xFFFFFFFF * 2
        issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        busy_run("multu", 5);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        // DIV -7 / 2 with an MTHI attempted mid-flight
        issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk("div_busy_hi", {31'd0, Busy}, 32'd1);
            if (i == 2) begin
                Start = 1'b1;
                Op    = MDU_MTHI;
                A     = 32'd5;
            end
            if (i == 3) begin
                Start = 1'b0;
                chk("div_mthi_ignored", HI, 32'h00000001);
            end
            @(negedge clk);
        end
        chk("div_busy_lo", {31'd0, Busy}, 32'd0);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        // DIV 7 / -2: quotient -3, remainder +1
        issue(MDU_DIV, 32'd7, 32'hFFFFFFFE);
        busy_run("div2", 10);
        chk("div2_lo", LO, 32'hFFFFFFFD);
        chk("div2_hi", HI, 32'h00000001);

        // Signed overflow corner
        issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        busy_run("divovf", 10);
        chk("divovf_lo", LO, 32'h80000000);
        chk("divovf_hi", HI, 32'h00000000);

        // DIVU treats operands as unsigned
        issue(MDU_DIVU, 32'hFFFFFFF9, 32'd2);
        busy_run("divu", 10);
        chk("divu_lo", LO, 32'h7FFFFFFC);
        chk("divu_hi", HI, 32'h00000001);

        // MTLO is immediate and never raises Busy
        issue(MDU_MTLO, 32'h12345678, 32'd0);
        chk("mtlo_lo", LO, 32'h12345678);
        chk("mtlo_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        chk("mtlo_busy2", {31'd0, Busy}, 32'd0);

        // Divide by zero: full latency, no commit
        issue(MDU_DIVU, 32'd9, 32'd0);
        busy_run("divz", 10);
        chk("divz_lo", LO, 32'h12345678);
        chk("divz_hi", HI, 32'h00000001);

        // Reset in the middle of a DIV
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        chk("rstmid_busy_pre", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_hi", HI, 32'h0);
        chk("rstmid_lo", LO, 32'h0);
        repeat (8) @(negedge clk);
        chk("rstmid_busy_late", {31'd0, Busy}, 32'd0);
        chk("rstmid_hi_late", HI, 32'h0);
        chk("rstmid_lo_late", LO, 32'h0);

        // Back-to-back: Start held; MTLO must land at E+6, not E+5
        Start = 1'b1;
        Op    = MDU_MULT;
        A     = 32'd3;
        B     = 32'd4;
        @(posedge clk);
        @(negedge clk);
        Op = MDU_MTLO;
        A  = 32'hCAFE0000;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_busy_hi", {31'd0, Busy}, 32'd1);
            chk("b2b_lo_hold", LO, 32'h0);
            @(negedge clk);
        end
        chk("b2b_busy_lo", {31'd0, Busy}, 32'd0);
        chk("b2b_mult_lo", LO, 32'h0000000C);
        chk("b2b_mult_hi", HI, 32'h0);
        @(negedge clk);
        Start = 1'b0;
        chk("b2b_mtlo_lo", LO, 32'hCAFE0000);
        chk("b2b_mtlo_hi", HI, 32'h0);
        chk("b2b_mtlo_busy", {31'd0, Busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
